reg_read_ctrl: RTL and testbench

REG_READ_CTRL -- requirements
Module: reg_read_ctrl

---
 rtl/reg_pkg.sv | 14 +
 rtl/reg_rsp_fifo.sv | 76 +++++++
 rtl/reg_read_ctrl.sv | 74 +++++++
 tb/tb_reg_read_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared constants and types for the register read controller.
package reg_pkg;

  localparam int unsigned DATA_WIDTH_MIN = 8;
  localparam int unsigned DATA_WIDTH_MAX = 32;

  // Occupancy of the 2-entry response buffer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/reg_rsp_fifo.sv
// Two-entry in-order response buffer holding {fwd, data} snapshots.
// Flags and head entry are registered; pointers wrap modulo 2.
module reg_rsp_fifo
  import reg_pkg::*;
#(
  parameter int unsigned ENTRY_W = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic               valid_o,
  output logic               ready_o,
  output logic [ENTRY_W-1:0] head_o
);

  fifo_state_e        state_q, state_d;
  logic               wptr_q, wptr_d;
  logic               rptr_q, rptr_d;
  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               valid_q, ready_q;

  // Next state, pointers and next head entry
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    if (push_i && !pop_i) begin
      case (state_q)
        EMPTY:   state_d = ONE;
        ONE:     state_d = FULL;
        default: state_d = state_q;
      endcase
    end else if (pop_i && !push_i) begin
      case (state_q)
        FULL:    state_d = ONE;
        ONE:     state_d = EMPTY;
        default: state_d = state_q;
      endcase
    end
    // Head comes straight from the push when the slot being written is the next head
    if (push_i && (wptr_q == rptr_d)) head_d = push_data_i;
    else                              head_d = mem_q[rptr_d];
  end

  // State, storage and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      if (push_i) mem_q[wptr_q] <= push_data_i;
      head_q  <= head_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign head_o  = head_q;

endmodule

// File: rtl/reg_read_ctrl.sv
// Register-bank read controller: accepts read requests, captures bank data
// (optionally forwarding a same-cycle write), and returns responses in order
// through a 2-entry buffer.
// Optional feature macro: REG_READ_CTRL_FWD_EN enables write-to-read forwarding.
module reg_read_ctrl
  import reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_fwd
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  // Reject unsupported data widths at elaboration
  if ((DATA_WIDTH < DATA_WIDTH_MIN) || (DATA_WIDTH > DATA_WIDTH_MAX)) begin : g_width_check
    $error("reg_read_ctrl: DATA_WIDTH %0d outside supported range", DATA_WIDTH);
  end

  logic                  accept;
  logic                  pop;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [ENTRY_W-1:0]    head;

  assign accept  = req_valid && req_ready;
  assign pop     = rsp_valid && rsp_ready;
  assign rd_en   = accept;
  assign rd_addr = req_addr;

`ifdef REG_READ_CTRL_FWD_EN
  // A same-cycle write to the requested register wins over the bank read
  assign fwd_hit  = wr_en && (wr_addr == req_addr);
  assign cap_data = fwd_hit ? wr_data : rd_data;
`else
  // Bank read only; write snoop port is ignored
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign fwd_hit   = 1'b0;
  assign cap_data  = rd_data;
`endif

  reg_rsp_fifo #(
    .ENTRY_W(ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (accept),
    .push_data_i ({fwd_hit, cap_data}),
    .pop_i       (pop),
    .valid_o     (rsp_valid),
    .ready_o     (req_ready),
    .head_o      (head)
  );

  assign rsp_fwd  = head[ENTRY_W-1];
  assign rsp_data = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_reg_read_ctrl.sv
// Bench for reg_read_ctrl: queue-based response model checked every cycle,
// plus directed literal expectations for the key scenarios.
module tb_reg_read_ctrl;

`ifdef REG_READ_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = 2'd0;
  logic       rd_en;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_fwd;

  // Second instance at the widest data width
  logic        req_valid32 = 1'b0;
  logic        req_ready32;
  logic [1:0]  req_addr32 = 2'd0;
  logic        rd_en32;
  logic [1:0]  rd_addr32;
  logic [31:0] rd_data32;
  logic        rsp_valid32;
  logic        rsp_ready32 = 1'b1;
  logic [31:0] rsp_data32;
  logic        rsp_fwd32;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] bank [4] = '{8'h10, 8'h11, 8'h5A, 8'h33};

  typedef struct {
    logic       fwd;
    logic [7:0] data;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  assign rd_data   = bank[rd_addr];
  assign rd_data32 = (rd_addr32 == 2'd1) ? 32'hDEADBEEF : 32'h0000_0000;

  reg_read_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_fwd(rsp_fwd)
  );

  reg_read_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid32), .req_ready(req_ready32), .req_addr(req_addr32),
    .rd_en(rd_en32), .rd_addr(rd_addr32), .rd_data(rd_data32),
    .wr_en(1'b0), .wr_addr(2'd0), .wr_data(32'd0),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32),
    .rsp_data(rsp_data32), .rsp_fwd(rsp_fwd32)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // External register bank: writes land at the clock edge
  always @(posedge clk) begin
    if (wr_en) bank[wr_addr] <= wr_data;
  end

  // Behavioural model: ordered list of pending responses, depth 2
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      ent_t e;
      bit   do_pop;
      bit   do_push;
      do_pop  = (q.size() > 0) && rsp_ready;
      do_push = req_valid && (q.size() < 2);
      e.fwd   = FWD && wr_en && (wr_addr == req_addr);
      e.data  = e.fwd ? wr_data : bank[req_addr];
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
    chk("req_ready", 32'(req_ready), 32'(q.size() < 2));
    chk("rd_en",     32'(rd_en),     32'(req_valid && (q.size() < 2)));
    chk("rd_addr",   32'(rd_addr),   32'(req_addr));
    if (q.size() > 0) begin
      chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
      chk("rsp_fwd",  32'(rsp_fwd),  32'(q[0].fwd));
    end else if (!reset_n) begin
      chk("rst_data", 32'(rsp_data), 32'h0);
      chk("rst_fwd",  32'(rsp_fwd),  32'h0);
    end
  end

  initial begin
    // Reset: request presented but must not be accepted
    req_valid = 1'b1;
    req_addr  = 2'd2;
    repeat (3) cyc();
    chk("reset_rd_en",     32'(rd_en),     32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h1);
    chk("reset_rsp_data",  32'(rsp_data),  32'h0);
    chk("reset_rsp_fwd",   32'(rsp_fwd),   32'h0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    cyc();
    chk("no_rsp_after_reset", 32'(rsp_valid), 32'h0);

    // Plain read of reg2
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 2'd2;
    cyc();
    req_valid = 1'b0;
    chk("rd2_valid", 32'(rsp_valid), 32'h1);
    chk("rd2_data",  32'(rsp_data),  32'h5A);
    chk("rd2_fwd",   32'(rsp_fwd),   32'h0);
    cyc();
    chk("rd2_popped", 32'(rsp_valid), 32'h0);

    // Read of reg1 colliding with a write of 0xC3
    req_valid = 1'b1;
    req_addr  = 2'd1;
    wr_en     = 1'b1;
    wr_addr   = 2'd1;
    wr_data   = 8'hC3;
    cyc();
    req_valid = 1'b0;
    wr_en     = 1'b0;
    chk("fwd_data", 32'(rsp_data), FWD ? 32'hC3 : 32'h11);
    chk("fwd_flag", 32'(rsp_fwd),  FWD ? 32'h1  : 32'h0);
    cyc();

    // Back-to-back requests against a stalled consumer
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 2'd0;
    cyc();
    req_addr  = 2'd1;
    cyc();
    chk("full_req_ready", 32'(req_ready), 32'h0);
    req_addr  = 2'd2;
    cyc();
    chk("full_hold_ready", 32'(req_ready), 32'h0);
    chk("full_head0",      32'(rsp_data),  32'h10);
    rsp_ready = 1'b1;
    cyc();
    chk("pop0_head1",  32'(rsp_data),  32'hC3);
    chk("pop0_ready",  32'(req_ready), 32'h1);
    cyc();
    chk("pop1_head2",  32'(rsp_data),  32'h5A);
    chk("pop1_valid",  32'(rsp_valid), 32'h1);
    req_valid = 1'b0;
    cyc();
    chk("drained", 32'(rsp_valid), 32'h0);

    // Snapshot must survive a later write to the same register
    rsp_ready = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 2'd3;
    wr_data   = 8'h22;
    cyc();
    wr_en     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 2'd3;
    cyc();
    req_valid = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'h99;
    cyc();
    wr_en = 1'b0;
    chk("snapshot_data", 32'(rsp_data), 32'h22);
    rsp_ready = 1'b1;
    cyc();
    chk("snapshot_popped", 32'(rsp_valid), 32'h0);

    // Reset while FULL discards everything
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 2'd0;
    cyc();
    req_addr  = 2'd2;
    cyc();
    req_valid = 1'b0;
    chk("pre_reset_full", 32'(req_ready), 32'h0);
    reset_n   = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 2'd2;
    wr_data   = 8'h6B;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    chk("midrst_data",  32'(rsp_data),  32'h0);
    cyc();
    wr_en     = 1'b0;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 2'd2;
    cyc();
    req_valid = 1'b0;
    chk("post_rst_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_data",  32'(rsp_data),  32'h6B);
    cyc();

    // Wide instance: full 32-bit value returned
    req_valid32 = 1'b1;
    req_addr32  = 2'd1;
    cyc();
    req_valid32 = 1'b0;
    chk("w32_valid", 32'(rsp_valid32), 32'h1);
    chk("w32_data",  rsp_data32,       32'hDEADBEEF);
    chk("w32_fwd",   32'(rsp_fwd32),   32'h0);
    cyc();

    // Mixed traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 2'($urandom_range(0, 3));
      rsp_ready = 1'($urandom_range(0, 1));
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 2'($urandom_range(0, 3));
      wr_data   = 8'($urandom_range(0, 255));
      cyc();
    end
    req_valid = 1'b0;
    wr_en     = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) cyc();
    chk("final_empty", 32'(rsp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
